// File: rtl/frontend_fetch_ctrl_pkg.sv
// Shared types and helpers for the hart 0 fetch controller.
//   fetch_state_e : controller sequencing states
//   fetch_pc_t    : fetch address at the default 32-bit width
//   cnt_width()   : bits needed to hold an in-flight count of 0..max_inflight
package frontend_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StFlush
  } fetch_state_e;

  localparam int unsigned FetchPcW = 32;
  typedef logic [FetchPcW-1:0] fetch_pc_t;

  function automatic int unsigned cnt_width(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/frontend_inflight_tracker.sv
// Counts accepted-but-unanswered fetches and the number of those that went stale
// because of a redirect.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_fire_i        : a fetch request was accepted this cycle
//   resp_fire_i       : a fetch response is delivered this cycle
//   redirect_i        : core redirect this cycle
//   inflight_q_o      : registered in-flight count
//   inflight_next_o   : in-flight count after this cycle's fire/response
//   resp_kill_o       : the response delivered this cycle is stale
module frontend_inflight_tracker
  import frontend_fetch_ctrl_pkg::*;
#(
  parameter int unsigned MaxInflight = 2,
  parameter int unsigned CntW        = cnt_width(MaxInflight)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_fire_i,
  input  logic            resp_fire_i,
  input  logic            redirect_i,
  output logic [CntW-1:0] inflight_q_o,
  output logic [CntW-1:0] inflight_next_o,
  output logic            resp_kill_o
);

  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] kill_cnt_q, kill_cnt_d;
  logic            resp_ok;

  // A response with nothing outstanding is ignored so the counter stays at 0.
  assign resp_ok = resp_fire_i && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire_i && !resp_ok) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!req_fire_i && resp_ok) begin
      inflight_d = inflight_q - CntW'(1);
    end
  end

  // Everything still outstanding after a redirect is stale, including a response
  // that lands in the redirect cycle itself.
  assign resp_kill_o = !rst_i && resp_fire_i && ((kill_cnt_q != '0) || redirect_i);

  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (redirect_i) begin
      kill_cnt_d = inflight_q - CntW'(resp_ok);
    end else if (resp_kill_o) begin
      kill_cnt_d = kill_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      kill_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign inflight_q_o    = inflight_q;
  assign inflight_next_o = inflight_d;

  resp_without_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_fire_i |-> (inflight_q != '0));

  kill_le_inflight_a: assert property (@(posedge clk_i) disable iff (rst_i)
    kill_cnt_q <= inflight_q);

endmodule

// File: rtl/frontend_fetch_ctrl.sv
// Drives hart 0's fetch stream into the Frontend: sequential fetch PCs, core
// redirects, stale-response marking and the fence.i drain-then-flush sequence.
//   clock, reset     : sole clock, synchronous active-high reset
//   reset_pc         : PC loaded while reset is high
//   redirect_valid/pc: one-cycle core redirect and its target
//   core_stall       : suppress new fetch requests
//   req_valid/ready  : fetch request handshake, req_pc is the fetch address
//   resp_fire        : Frontend response delivered; resp_kill marks it stale
//   fencei_valid     : level fence.i request, fencei_done pulses on completion
//   flush_icache     : one-cycle icache invalidate
//   fetch_idle       : nothing outstanding and fetching normally
module frontend_fetch_ctrl
  import frontend_fetch_ctrl_pkg::*;
#(
  parameter int unsigned VADDR_W      = 32,
  parameter int unsigned FETCH_BYTES  = 4,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VADDR_W-1:0] reset_pc,
  input  logic               redirect_valid,
  input  logic [VADDR_W-1:0] redirect_pc,
  input  logic               core_stall,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [VADDR_W-1:0] req_pc,
  input  logic               resp_fire,
  output logic               resp_kill,
  input  logic               fencei_valid,
  output logic               fencei_done,
  output logic               flush_icache,
  output logic               fetch_idle
);

  localparam int unsigned CntW = cnt_width(MAX_INFLIGHT);

  fetch_state_e       state_q, state_d;
  logic [VADDR_W-1:0] pc_q, pc_d;
  logic [CntW-1:0]    inflight_q, inflight_next;
  logic               req_fire;

  frontend_inflight_tracker #(
    .MaxInflight (MAX_INFLIGHT),
    .CntW        (CntW)
  ) u_tracker (
    .clk_i           (clock),
    .rst_i           (reset),
    .req_fire_i      (req_fire),
    .resp_fire_i     (resp_fire),
    .redirect_i      (redirect_valid),
    .inflight_q_o    (inflight_q),
    .inflight_next_o (inflight_next),
    .resp_kill_o     (resp_kill)
  );

  // Only the registered count gates issue, so a response never combinationally
  // re-opens the request slot in the same cycle.
  assign req_valid = !reset && (state_q == StFetch) && !core_stall && !redirect_valid &&
                     !fencei_valid && (inflight_q < CntW'(MAX_INFLIGHT));
  assign req_fire   = req_valid && req_ready;
  assign req_pc     = pc_q;
  assign fetch_idle = !reset && (state_q == StFetch) && (inflight_q == '0);

  always_comb begin
    state_d      = state_q;
    flush_icache = 1'b0;
    fencei_done  = 1'b0;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (fencei_valid) state_d = StDrain;
      // Looking at the next count lets the flush follow the last response directly.
      StDrain: if (inflight_next == '0) state_d = StFlush;
      StFlush: begin
        flush_icache = !reset;
        fencei_done  = !reset;
        state_d      = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // A redirect retargets the PC in every state but does not abort a pending flush.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req_fire) begin
      pc_d = pc_q + VADDR_W'(FETCH_BYTES);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= reset_pc;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_frontend_fetch_ctrl.sv
module tb_frontend_fetch_ctrl;
  import frontend_fetch_ctrl_pkg::*;

  logic      clock = 1'b0;
  logic      reset;
  fetch_pc_t reset_pc;
  logic      redirect_valid;
  fetch_pc_t redirect_pc;
  logic      core_stall;
  logic      req_valid;
  logic      req_ready;
  fetch_pc_t req_pc;
  logic      resp_fire;
  logic      resp_kill;
  logic      fencei_valid;
  logic      fencei_done;
  logic      flush_icache;
  logic      fetch_idle;

  always #5 clock = ~clock;

  frontend_fetch_ctrl #(
    .VADDR_W      (32),
    .FETCH_BYTES  (4),
    .MAX_INFLIGHT (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .reset_pc       (reset_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .core_stall     (core_stall),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .resp_fire      (resp_fire),
    .resp_kill      (resp_kill),
    .fencei_valid   (fencei_valid),
    .fencei_done    (fencei_done),
    .flush_icache   (flush_icache),
    .fetch_idle     (fetch_idle)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic      rst;
    logic      rdr;
    fetch_pc_t rdr_pc;
    logic      stall;
    logic      ready;
    logic      resp;
    logic      fencei;
    logic      e_rv;
    fetch_pc_t e_pc;
    logic      e_kill;
    logic      e_flush;
    logic      e_idle;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdr, input fetch_pc_t rdr_pc,
                              input logic stall, input logic ready, input logic resp,
                              input logic fencei, input logic e_rv, input fetch_pc_t e_pc,
                              input logic e_kill, input logic e_flush, input logic e_idle);
    vec_t v;
    v.rst = rst; v.rdr = rdr; v.rdr_pc = rdr_pc; v.stall = stall; v.ready = ready;
    v.resp = resp; v.fencei = fencei; v.e_rv = e_rv; v.e_pc = e_pc; v.e_kill = e_kill;
    v.e_flush = e_flush; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic rdr, input fetch_pc_t rdr_pc,
                       input logic stall, input logic ready, input logic resp,
                       input logic fencei);
    reset = rst; redirect_valid = rdr; redirect_pc = rdr_pc; core_stall = stall;
    req_ready = ready; resp_fire = resp; fencei_valid = fencei;
  endtask

  task automatic check_outs(input string tag, input logic e_rv, input fetch_pc_t e_pc,
                            input logic e_kill, input logic e_flush, input logic e_idle,
                            input logic chk_pc);
    check({tag, ".req_valid"}, 32'(req_valid), 32'(e_rv));
    if (chk_pc) check({tag, ".req_pc"}, req_pc, e_pc);
    check({tag, ".resp_kill"}, 32'(resp_kill), 32'(e_kill));
    check({tag, ".flush_icache"}, 32'(flush_icache), 32'(e_flush));
    check({tag, ".fencei_done"}, 32'(fencei_done), 32'(e_flush));
    check({tag, ".fetch_idle"}, 32'(fetch_idle), 32'(e_idle));
  endtask

  // Reference model: one stale flag per outstanding fetch, oldest first.
  bit        m_q[$];
  fetch_pc_t m_pc;
  bit        m_started, m_drain, m_flush;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit fence_on;
    logic e_rv, e_kill, e_flush, e_idle, fire;

    reset_pc = 32'h2000_0000;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // rst rdr rdr_pc stall ready resp fencei | rv pc kill flush idle
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h2000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h2000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 1, 32'h2000_0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 0, 1, 32'h2000_0004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 0, 1, 32'h2000_0008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h2000_000c, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 1, 32'h2000_000c, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h2000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 0, 0, 32'h2000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 1, 32'h2000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h8000_0100, 0, 1, 0, 0, 0, 32'h2000_0014, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 0, 0, 32'h8000_0100, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 0, 1, 32'h8000_0100, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 0, 1, 32'h8000_0104, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h8000_0104, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 32'h8000_0104, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0100, 0, 0, 1, 0, 0, 32'h0000_0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0000_0100, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0000_0100, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdr, vecs[i].rdr_pc, vecs[i].stall, vecs[i].ready,
            vecs[i].resp, vecs[i].fencei);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_pc, vecs[i].e_kill,
                 vecs[i].e_flush, vecs[i].e_idle, 1'b1);
      tick();
    end

    // fence.i with two fetches in flight; responses at +2 and +5.
    drive(0, 0, '0, 0, 1, 0, 0); #1;
    check_outs("fence_pre0", 1, 32'h100, 0, 0, 1, 1'b1);
    tick();
    drive(0, 0, '0, 0, 1, 0, 0); #1;
    check_outs("fence_pre1", 1, 32'h104, 0, 0, 0, 1'b1);
    tick();
    for (int t = 0; t < 8; t++) begin
      drive(0, 0, '0, 0, 1, (t == 2) || (t == 5), t <= 6);
      #1;
      check_outs($sformatf("fence_t%0d", t), t == 7, 32'h108, 0, t == 6, t == 7, t == 7);
      tick();
    end

    // Reset while draining.
    drive(0, 0, '0, 0, 1, 0, 1); #1;
    check_outs("rstdrain_enter", 0, 32'h10c, 0, 0, 0, 1'b1);
    tick();
    drive(0, 0, '0, 0, 1, 0, 1); #1;
    check_outs("rstdrain_drain", 0, 32'h10c, 0, 0, 0, 1'b1);
    tick();
    reset_pc = 32'h3000_0000;
    drive(1, 0, '0, 0, 1, 0, 0); #1;
    check_outs("rstdrain_rst", 0, 32'h10c, 0, 0, 0, 1'b0);
    tick();
    drive(0, 0, '0, 0, 0, 0, 0); #1;
    check_outs("rstdrain_idle", 0, 32'h3000_0000, 0, 0, 0, 1'b1);
    tick();
    drive(0, 0, '0, 0, 0, 0, 0); #1;
    check_outs("rstdrain_fetch", 1, 32'h3000_0000, 0, 0, 1, 1'b1);
    tick();

    // Randomised traffic against the reference model.
    fence_on = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 99) == 0);
      core_stall = ($urandom_range(0, 3) == 0);
      req_ready  = ($urandom_range(0, 3) != 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if (reset) begin
        redirect_valid = 1'b0;
        resp_fire      = 1'b0;
        fence_on       = 1'b0;
        fencei_valid   = 1'b0;
        reset_pc       = $urandom & 32'hFFFF_FFFC;
      end else begin
        redirect_valid = ($urandom_range(0, 9) == 0);
        resp_fire      = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
        if (!fence_on && ($urandom_range(0, 39) == 0)) fence_on = 1'b1;
        fencei_valid = fence_on;
      end

      e_rv    = !reset && m_started && !m_drain && !m_flush && !core_stall &&
                !redirect_valid && !fencei_valid && (m_q.size() < 2);
      e_kill  = !reset && resp_fire && (m_q.size() > 0) && (m_q[0] || redirect_valid);
      e_flush = !reset && m_flush;
      e_idle  = !reset && m_started && !m_drain && !m_flush && (m_q.size() == 0);
      #1;
      check_outs($sformatf("rnd%0d", c), e_rv, m_pc, e_kill, e_flush, e_idle, !reset);

      fire = e_rv && req_ready;
      if (reset) begin
        m_q.delete();
        m_pc      = reset_pc;
        m_started = 1'b0;
        m_drain   = 1'b0;
        m_flush   = 1'b0;
      end else begin
        if (resp_fire) void'(m_q.pop_front());
        if (fire) m_q.push_back(1'b0);
        if (redirect_valid) foreach (m_q[k]) m_q[k] = 1'b1;
        if (redirect_valid) m_pc = redirect_pc;
        else if (fire) m_pc = m_pc + 32'd4;
        if (!m_started) begin
          m_started = 1'b1;
        end else if (m_flush) begin
          m_flush  = 1'b0;
          fence_on = 1'b0;
        end else if (m_drain) begin
          if (m_q.size() == 0) begin
            m_drain = 1'b0;
            m_flush = 1'b1;
          end
        end else if (fencei_valid) begin
          m_drain = 1'b1;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
